// File: rtl/frame_downsampler.sv
// rtl/frame_downsampler.sv - crops a centred window of a raster grey stream and block-averages it into image_mem
module frame_downsampler #(
    parameter int IMG_W    = 640,
    parameter int IMG_H    = 480,
    parameter int X0       = 96,
    parameter int Y0       = 16,
    parameter int BLK_LOG2 = 4,
    parameter int OUT_DIM  = 28,
    parameter int INVERT   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       capture_req,
    input  logic       pix_valid,
    input  logic       pix_sof,
    input  logic [7:0] pix_data,
    output logic       busy,
    output logic       done,
    output logic       mem_we,
    output logic [9:0] mem_waddr,
    output logic [7:0] mem_wdata
);

    localparam int CROP  = OUT_DIM << BLK_LOG2;
    localparam int XW    = $clog2(IMG_W + 1);
    localparam int YW    = $clog2(IMG_H + 1);
    localparam int CW    = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
    localparam int ACC_W = 2 * BLK_LOG2 + 8;
    localparam int NBLK  = OUT_DIM * OUT_DIM;

    localparam logic [XW-1:0] X_LO   = XW'(X0);
    localparam logic [XW-1:0] X_HI   = XW'(X0 + CROP);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LO   = YW'(Y0);
    localparam logic [YW-1:0] Y_HI   = YW'(Y0 + CROP);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
    localparam logic [9:0]    W_LAST = 10'(NBLK - 1);

    typedef enum logic [1:0] {IDLE, ARM, CAP} state_t;

    state_t           state;
    logic [XW-1:0]    x;
    logic [YW-1:0]    y;
    logic [ACC_W-1:0] acc [OUT_DIM];
    logic [9:0]       wcount;
    logic             last_wr;

    logic             take;
    logic [XW-1:0]    cx;
    logic [YW-1:0]    cy;
    logic [XW-1:0]    dx;
    logic [YW-1:0]    dy;
    logic             in_crop;
    logic             blk_end;
    logic [CW-1:0]    col;
    logic [CW-1:0]    row;
    logic [7:0]       p;
    logic [ACC_W-1:0] acc_base;
    logic [ACC_W-1:0] sum;
    logic [9:0]       wcount_eff;

    // A sof pixel is always treated as (0,0) with empty accumulators, both
    // when arming and when a truncated frame restarts mid-capture.
    always_comb begin
        take       = pix_valid && ((state == ARM && pix_sof) || (state == CAP && !last_wr));
        cx         = pix_sof ? '0 : x;
        cy         = pix_sof ? '0 : y;
        dx         = cx - X_LO;
        dy         = cy - Y_LO;
        in_crop    = (cx >= X_LO) && (cx < X_HI) && (cy >= Y_LO) && (cy < Y_HI);
        blk_end    = in_crop && (&dx[BLK_LOG2-1:0]) && (&dy[BLK_LOG2-1:0]);
        col        = CW'(dx >> BLK_LOG2);
        row        = CW'(dy >> BLK_LOG2);
        p          = (INVERT != 0) ? (8'd255 - pix_data) : pix_data;
        acc_base   = pix_sof ? '0 : acc[col];
        sum        = acc_base + ACC_W'(p);
        wcount_eff = pix_sof ? '0 : wcount;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            x         <= '0;
            y         <= '0;
            wcount    <= '0;
            last_wr   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_we    <= 1'b0;
            mem_waddr <= '0;
            mem_wdata <= '0;
            for (int i = 0; i < OUT_DIM; i++) acc[i] <= '0;
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;
            if (state == IDLE) begin
                if (capture_req) begin
                    state <= ARM;
                    busy  <= 1'b1;
                end
            end else if (state == CAP && last_wr) begin
                // The cycle after the final write closes the capture.
                state   <= IDLE;
                busy    <= 1'b0;
                done    <= 1'b1;
                last_wr <= 1'b0;
            end else if (take) begin
                if (pix_sof) begin
                    state  <= CAP;
                    wcount <= '0;
                    for (int i = 0; i < OUT_DIM; i++) acc[i] <= '0;
                end
                if (cx == X_LAST) begin
                    x <= '0;
                    y <= (cy == Y_LAST) ? '0 : cy + YW'(1);
                end else begin
                    x <= cx + XW'(1);
                    y <= cy;
                end
                if (in_crop) acc[col] <= blk_end ? '0 : sum;
                if (blk_end) begin
                    mem_we    <= 1'b1;
                    mem_waddr <= 10'(row) * 10'(OUT_DIM) + 10'(col);
                    mem_wdata <= sum[2*BLK_LOG2 +: 8];
                    wcount    <= wcount_eff + 10'd1;
                    if (wcount_eff == W_LAST) last_wr <= 1'b1;
                end
            end
        end
    end

endmodule
